// File: rtl/rtc_seq.sv
// uPD4990A serial sequencer: turns one START into a timed command/write/read
// transaction on DIN/CLK/STROBE, and passes CPU_CTRL straight through when idle.
module rtc_seq #(
  parameter int CLK_DIV   = 12,
  parameter int STB_WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  CPU_CTRL,
  input  logic        START,
  input  logic        ABORT,
  input  logic [1:0]  OP,
  input  logic [3:0]  CMD,
  input  logic [47:0] WR_DATA,
  input  logic        RTC_DOUT,
  output logic        RTC_DIN,
  output logic        RTC_CLK,
  output logic        RTC_STROBE,
  output logic [47:0] RD_DATA,
  output logic        BUSY,
  output logic        DONE
);
  localparam int MAXL = (CLK_DIV > STB_WIDTH) ? CLK_DIV : STB_WIDTH;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] D_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STB_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, SHIFT_LO, SHIFT_HI, PRE_STB, STB, GAP, READ_LO, READ_HI, FINISH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [5:0]    bit_cnt, bit_n;
  logic [51:0]   sreg, sreg_n;
  logic [1:0]    op_q, op_n;
  logic          sample;
  logic          din_q, clk_q, stb_q, busy_q, done_q;
  logic          din_n, clk_n, stb_n;
  logic          d_end, s_end;
  logic [5:0]    bit_last;

  assign d_end    = (cnt == D_LAST);
  assign s_end    = (cnt == S_LAST);
  assign bit_last = (op_q == 2'b01) ? 6'd51 : 6'd3;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_cnt;
    sreg_n  = sreg;
    op_n    = op_q;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (START && !ABORT && OP != 2'b11) begin
          op_n    = OP;
          sreg_n  = (OP == 2'b01) ? {CMD, WR_DATA} : {48'b0, CMD};
          bit_n   = '0;
          state_n = SHIFT_LO;
        end
      end
      SHIFT_LO: if (d_end) begin
        cnt_n   = '0;
        state_n = SHIFT_HI;
      end
      SHIFT_HI: if (d_end) begin
        cnt_n  = '0;
        sreg_n = sreg >> 1;
        if (bit_cnt == bit_last) begin
          bit_n   = '0;
          state_n = PRE_STB;
        end else begin
          bit_n   = bit_cnt + 6'd1;
          state_n = SHIFT_LO;
        end
      end
      PRE_STB: if (d_end) begin
        cnt_n   = '0;
        state_n = STB;
      end
      STB: if (s_end) begin
        cnt_n   = '0;
        state_n = GAP;
      end
      GAP: if (d_end) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = (op_q == 2'b10) ? READ_LO : FINISH;
      end
      READ_LO: if (d_end) begin
        cnt_n   = '0;
        sample  = 1'b1;
        state_n = READ_HI;
      end
      READ_HI: if (d_end) begin
        cnt_n = '0;
        if (bit_cnt == 6'd47) begin
          bit_n   = '0;
          state_n = FINISH;
        end else begin
          bit_n   = bit_cnt + 6'd1;
          state_n = READ_LO;
        end
      end
      FINISH: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (ABORT && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      bit_n   = '0;
      sample  = 1'b0;
    end

    // Pins are registered from the next state so they change exactly on state edges.
    din_n = (state_n == SHIFT_LO || state_n == SHIFT_HI) ? sreg_n[0] : 1'b0;
    clk_n = (state_n == SHIFT_HI || state_n == READ_HI);
    stb_n = (state_n == STB);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
      op_q    <= '0;
      RD_DATA <= '0;
      din_q   <= 1'b0;
      clk_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      sreg    <= sreg_n;
      op_q    <= op_n;
      if (sample) RD_DATA[bit_cnt] <= RTC_DOUT;
      din_q   <= din_n;
      clk_q   <= clk_n;
      stb_q   <= stb_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == FINISH);
    end
  end

  assign RTC_DIN    = (state == IDLE) ? CPU_CTRL[0] : din_q;
  assign RTC_CLK    = (state == IDLE) ? CPU_CTRL[1] : clk_q;
  assign RTC_STROBE = (state == IDLE) ? CPU_CTRL[2] : stb_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
endmodule

// File: tb/tb_rtc_seq.sv
// Scenario bench for rtc_seq: expected DIN bits are queued at START, observed bits
// are collected on each RTC_CLK rise, and timing/readback is checked per scenario.
module tb_rtc_seq;
  localparam int D = 2;
  localparam int S = 3;
  localparam int L_CMD = 2*D*4 + 2*D + S;
  localparam int L_WR  = 2*D*52 + 2*D + S;
  localparam int L_RD  = L_CMD + 96*D;

  logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, ABORT = 1'b0, RTC_DOUT = 1'b0;
  logic [2:0]  CPU_CTRL = 3'b000;
  logic [1:0]  OP = 2'b00;
  logic [3:0]  CMD = 4'h0;
  logic [47:0] WR_DATA = '0;
  logic        RTC_DIN, RTC_CLK, RTC_STROBE, BUSY, DONE;
  logic [47:0] RD_DATA;

  rtc_seq #(.CLK_DIV(D), .STB_WIDTH(S)) dut (
    .CLK(CLK), .RESET(RESET), .CPU_CTRL(CPU_CTRL), .START(START), .ABORT(ABORT),
    .OP(OP), .CMD(CMD), .WR_DATA(WR_DATA), .RTC_DOUT(RTC_DOUT),
    .RTC_DIN(RTC_DIN), .RTC_CLK(RTC_CLK), .RTC_STROBE(RTC_STROBE),
    .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  logic exp_q[$];
  logic obs_q[$];
  int k_cnt, done_k, done_cnt, stb_len, rd_k;
  logic prev_clk, prev_stb, in_read, is_read_g, busy0;
  logic [47:0] rval_g, rd_model;

  task automatic drive_start(input logic [1:0] op, input logic [3:0] cmd,
                             input logic [47:0] wd, input logic [47:0] rv);
    @(negedge CLK);
    OP = op; CMD = cmd; WR_DATA = wd; START = 1'b1;
    rval_g = rv; is_read_g = (op == 2'b10);
    exp_q.delete(); obs_q.delete();
    if (op == 2'b01) for (int i = 0; i < 48; i++) exp_q.push_back(wd[i]);
    if (op != 2'b11) for (int i = 0; i < 4; i++) exp_q.push_back(cmd[i]);
    @(posedge CLK);
    #1 START = 1'b0;
    k_cnt = -1; done_k = -1; done_cnt = 0; stb_len = 0;
    prev_clk = 1'b0; prev_stb = 1'b0; in_read = 1'b0; rd_k = 0; busy0 = 1'b0;
  endtask

  // Monitor plus RTC read model: advances DOUT on each RTC_CLK rise of the read phase.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      k_cnt++;
      if (k_cnt == 0) busy0 = BUSY;
      if (RTC_CLK && !prev_clk) begin
        if (in_read) begin
          rd_k++;
          if (rd_k < 48) RTC_DOUT = rval_g[rd_k];
        end else obs_q.push_back(RTC_DIN);
      end
      if (RTC_STROBE) stb_len++;
      if (prev_stb && !RTC_STROBE && is_read_g && !in_read) begin
        in_read = 1'b1; rd_k = 0; RTC_DOUT = rval_g[0];
      end
      prev_clk = RTC_CLK; prev_stb = RTC_STROBE;
      if (DONE) begin done_cnt++; done_k = k_cnt; break; end
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    n_chk++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", BUSY, DONE); end
    n_chk++; if (RD_DATA !== 48'h0) begin n_fail++;
      $display("FAIL reset_rd_data got %h required 0", RD_DATA); end
    for (int v = 0; v < 8; v += 3) begin
      CPU_CTRL = 3'(v); #1;
      n_chk++; if ({RTC_STROBE, RTC_CLK, RTC_DIN} !== 3'(v)) begin n_fail++;
        $display("FAIL reset_passthru got %b required %b", {RTC_STROBE, RTC_CLK, RTC_DIN}, 3'(v)); end
    end
    CPU_CTRL = 3'b000;
    RESET = 1'b0;
    rd_model = '0;
  endtask

  task automatic test_cmd;
    drive_start(2'b00, 4'b0011, '0, '0);
    watch(400);
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL cmd_busy_rise got %b required 1", busy0); end
    n_chk++; if (done_k != L_CMD) begin n_fail++; $display("FAIL cmd_done_cycle got %0d required %0d", done_k, L_CMD); end
    n_chk++; if (stb_len != S) begin n_fail++; $display("FAIL cmd_stb_len got %0d required %0d", stb_len, S); end
    n_chk++; if (obs_q.size() != exp_q.size()) begin n_fail++;
      $display("FAIL cmd_rises got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL cmd_din got %b required %b", o, e); end
    end
    n_chk++; if (RD_DATA !== rd_model) begin n_fail++; $display("FAIL cmd_rd_hold got %h required %h", RD_DATA, rd_model); end
    @(negedge CLK);
    n_chk++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++;
      $display("FAIL cmd_end busy=%b done=%b required 0 0", BUSY, DONE); end
  endtask

  task automatic test_write;
    int bad;
    bad = 0;
    drive_start(2'b01, 4'b0010, 48'h25_12_31_23_59_45, '0);
    watch(600);
    n_chk++; if (done_k != L_WR) begin n_fail++; $display("FAIL wr_done_cycle got %0d required %0d", done_k, L_WR); end
    n_chk++; if (obs_q.size() != 52) begin n_fail++; $display("FAIL wr_rises got %0d required 52", obs_q.size()); end
    n_chk++; if (stb_len != S) begin n_fail++; $display("FAIL wr_stb_len got %0d required %0d", stb_len, S); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; bad++;
        if (bad < 4) $display("FAIL wr_din got %b required %b", o, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_read;
    drive_start(2'b10, 4'd3, '0, 48'h99_01_06_12_00_30);
    watch(600);
    rd_model = 48'h99_01_06_12_00_30;
    n_chk++; if (done_k != L_RD) begin n_fail++; $display("FAIL rd_done_cycle got %0d required %0d", done_k, L_RD); end
    n_chk++; if (RD_DATA !== rd_model) begin n_fail++; $display("FAIL rd_data got %h required %h", RD_DATA, rd_model); end
    n_chk++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL rd_cmd_rises got %0d required 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL rd_cmd_din got %b required %b", o, e); end
    end
    @(negedge CLK);
  endtask

  task automatic test_ignored;
    int seen;
    seen = 0;
    @(negedge CLK);
    OP = 2'b11; CMD = 4'hF; START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (BUSY || DONE) seen++;
    end
    START = 1'b0;
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL op11_ignored busy/done cycles got %0d required 0", seen); end
    drive_start(2'b00, 4'b0101, '0, '0);
    watch(10);
    OP = 2'b01; CMD = 4'b1110; START = 1'b1;
    watch(1);
    START = 1'b0;
    watch(400);
    n_chk++; if (done_k != L_CMD) begin n_fail++; $display("FAIL busy_start_done got %0d required %0d", done_k, L_CMD); end
    n_chk++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL busy_start_rises got %0d required 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL busy_start_din got %b required %b", o, e); end
    end
    @(negedge CLK);
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL busy_start_requeued busy=%b required 0", BUSY); end
  endtask

  task automatic test_abort;
    drive_start(2'b01, 4'b1001, 48'hFEDC_BA98_7654, '0);
    watch(2*D*20 + 1);
    ABORT = 1'b1; CPU_CTRL = 3'b101;
    @(negedge CLK);
    ABORT = 1'b0;
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b required 0", BUSY); end
    n_chk++; if ({RTC_STROBE, RTC_CLK, RTC_DIN} !== 3'b101) begin n_fail++;
      $display("FAIL abort_pins got %b required 101", {RTC_STROBE, RTC_CLK, RTC_DIN}); end
    n_chk++; if (obs_q.size() != 20) begin n_fail++; $display("FAIL abort_rises got %0d required 20", obs_q.size()); end
    watch(300);
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done got %0d pulses required 0", done_cnt); end
    CPU_CTRL = 3'b000;
  endtask

  task automatic test_reset_mid;
    drive_start(2'b10, 4'd3, '0, 48'hA5A5_5A5A_F00F);
    watch(150);
    CPU_CTRL = 3'b011;
    RESET = 1'b1;
    #1;
    rd_model = '0;
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b required 0", BUSY); end
    n_chk++; if (RD_DATA !== rd_model) begin n_fail++; $display("FAIL rstmid_rd got %h required %h", RD_DATA, rd_model); end
    n_chk++; if ({RTC_STROBE, RTC_CLK, RTC_DIN} !== 3'b011) begin n_fail++;
      $display("FAIL rstmid_pins got %b required 011", {RTC_STROBE, RTC_CLK, RTC_DIN}); end
    @(negedge CLK);
    RESET = 1'b0; CPU_CTRL = 3'b000;
    watch(20);
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done got %0d pulses required 0", done_cnt); end
    drive_start(2'b00, 4'b1010, '0, '0);
    watch(400);
    n_chk++; if (done_k != L_CMD) begin n_fail++; $display("FAIL rstmid_new_done got %0d required %0d", done_k, L_CMD); end
    n_chk++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL rstmid_new_rises got %0d required 4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic o, e; o = obs_q.pop_front(); e = exp_q.pop_front();
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL rstmid_new_din got %b required %b", o, e); end
    end
    n_chk++; if (RD_DATA !== rd_model) begin n_fail++; $display("FAIL rstmid_rd_hold got %h required %h", RD_DATA, rd_model); end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_write();
    test_read();
    test_ignored();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
